// File: rtl/nfca_pkg.sv
// Shared constants, sequence codes and FSM encoding for the NFC-A transmit framer.
package nfca_pkg;

  // Slot timing at 81.36 MHz: one bit slot is 128/fc, one pause is 32/fc.
  localparam int BIT_CYCLES   = 768;
  localparam int PAUSE_CYCLES = 192;
  localparam int HALF         = BIT_CYCLES / 2;

  localparam int CNT_W = $clog2(BIT_CYCLES);
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_LAST     = cnt_t'(BIT_CYCLES - 1);
  localparam cnt_t CNT_PAUSE    = cnt_t'(PAUSE_CYCLES);
  localparam cnt_t CNT_HALF     = cnt_t'(HALF);
  localparam cnt_t CNT_HALF_END = cnt_t'(HALF + PAUSE_CYCLES);

  // Modified Miller slot shapes.
  typedef enum logic [1:0] {
    SEQ_X = 2'd0,  // pause in the second half
    SEQ_Y = 2'd1,  // no pause
    SEQ_Z = 2'd2   // pause at slot start
  } seq_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SOC  = 3'd1,
    ST_DATA = 3'd2,
    ST_PAR  = 3'd3,
    ST_EOC0 = 3'd4,
    ST_EOCY = 3'd5
  } tx_state_t;

  // A one is always X; a zero is Y right after an X, otherwise Z.
  function automatic seq_t miller_enc(input logic bit_v, input logic prev_x);
    if (bit_v) return SEQ_X;
    return prev_x ? SEQ_Y : SEQ_Z;
  endfunction

  // Number of bits carried by a byte: a last byte may be partial (0 means 8).
  function automatic logic [3:0] nbits_of(input logic last, input logic [2:0] lastb);
    return (last && (lastb != 3'd0)) ? {1'b0, lastb} : 4'd8;
  endfunction

endpackage

// File: rtl/nfca_tx_frame_if.sv
// Byte stream into the NFC-A transmit framer.
// Handshake: a byte transfers on every rising clk edge where tvalid and tready
// are both 1. The master holds tdata/tlast/tlastb stable while tvalid is high
// and not yet accepted; tready does not depend on tvalid.
interface nfca_tx_frame_if;
  logic       tvalid;
  logic       tready;
  logic [7:0] tdata;
  logic       tlast;
  logic [2:0] tlastb;

  modport master (output tvalid, output tdata, output tlast, output tlastb, input tready);
  modport slave  (input tvalid, input tdata, input tlast, input tlastb, output tready);
endinterface

// File: rtl/nfca_tx_miller_seq.sv
// Bit-slot timer and Modified Miller waveform generator.
// The framer selects the shape of each slot; this block owns the slot counter.
module nfca_tx_miller_seq
  import nfca_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic start,      // frame begins: slot counter restarts at 0
  input  logic run,        // a frame is in progress
  input  seq_t seq,        // shape of the current slot
  output logic carrier_on,
  output logic slot_end    // last cycle of the current slot
);

  cnt_t cnt;

  assign slot_end = run && (cnt == CNT_LAST);

  // Slot counter: held at 0 between frames, wraps at the end of each slot.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (start || !run || slot_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + cnt_t'(1);
    end
  end

  // Registered modulation output; carrier stays on whenever no frame runs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      carrier_on <= 1'b1;
    end else if (!run) begin
      carrier_on <= 1'b1;
    end else begin
      case (seq)
        SEQ_Z:   carrier_on <= (cnt >= CNT_PAUSE);
        SEQ_X:   carrier_on <= (cnt < CNT_HALF) || (cnt >= CNT_HALF_END);
        default: carrier_on <= 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/nfca_tx_frame.sv
// NFC-A PCD->PICC transmit framer: serialises bytes LSB-first with optional
// odd parity and encodes them as Modified Miller between SOC and EOC.
module nfca_tx_frame
  import nfca_pkg::*;
(
  input  logic           clk,
  input  logic           rstn,
  input  logic           parity_en,
  nfca_tx_frame_if.slave tx,
  output logic           carrier_on,
  output logic           tx_busy,
  output logic           tx_done,
  output logic           tx_underrun,
  output tx_state_t      dbg_state
);

  tx_state_t  state;
  seq_t       seq_r;
  logic       prev_x;
  logic [7:0] cur_byte;
  logic       cur_last;
  logic [3:0] cur_nbits;
  logic [2:0] bit_idx;
  logic       par_en_r;
  logic       under_flag;

  logic       hold_full;
  logic [7:0] hold_data;
  logic       hold_last;
  logic [2:0] hold_lastb;
  logic       tready_r;

  logic       slot_end;
  logic       accept;
  logic       idle_start;
  logic       last_bit;
  logic       need_par;
  logic       byte_end;
  logic       take_hold;
  logic       hold_in;
  logic       hold_full_n;
  logic       next_bit;
  logic       par_bit;

  assign tx.tready = tready_r;
  assign dbg_state = state;

  // Handshake, byte-boundary and holding-register bookkeeping.
  always_comb begin
    accept      = tx.tvalid && tready_r;
    idle_start  = (state == ST_IDLE) && (hold_full || accept);
    last_bit    = ({1'b0, bit_idx} == (cur_nbits - 4'd1));
    need_par    = par_en_r && (cur_nbits == 4'd8);
    byte_end    = slot_end && (((state == ST_DATA) && last_bit && !need_par) ||
                               (state == ST_PAR));
    take_hold   = ((state == ST_IDLE) && hold_full) ||
                  (byte_end && !cur_last && hold_full);
    // In IDLE an accepted byte goes straight into the shifter.
    hold_in     = accept && (state != ST_IDLE);
    hold_full_n = hold_in || (hold_full && !take_hold);
    next_bit    = cur_byte[bit_idx + 3'd1];
    par_bit     = ~^cur_byte;
  end

  // One-byte holding register; refilling on the edge it empties is allowed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_full  <= 1'b0;
      hold_data  <= '0;
      hold_last  <= 1'b0;
      hold_lastb <= '0;
      tready_r   <= 1'b0;
    end else begin
      hold_full <= hold_full_n;
      tready_r  <= !hold_full_n;
      if (hold_in) begin
        hold_data  <= tx.tdata;
        hold_last  <= tx.tlast;
        hold_lastb <= tx.tlastb;
      end
    end
  end

  // Framer FSM: picks the sequence of the next slot at each slot end.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      seq_r       <= SEQ_Y;
      prev_x      <= 1'b0;
      cur_byte    <= '0;
      cur_last    <= 1'b0;
      cur_nbits   <= 4'd8;
      bit_idx     <= '0;
      par_en_r    <= 1'b0;
      under_flag  <= 1'b0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      tx_done     <= 1'b0;
      tx_underrun <= 1'b0;
      if (state == ST_IDLE) begin
        if (idle_start) begin
          state      <= ST_SOC;
          seq_r      <= SEQ_Z;
          prev_x     <= 1'b0;
          under_flag <= 1'b0;
          par_en_r   <= parity_en;
          tx_busy    <= 1'b1;
          if (hold_full) begin
            cur_byte  <= hold_data;
            cur_last  <= hold_last;
            cur_nbits <= nbits_of(hold_last, hold_lastb);
          end else begin
            cur_byte  <= tx.tdata;
            cur_last  <= tx.tlast;
            cur_nbits <= nbits_of(tx.tlast, tx.tlastb);
          end
        end
      end else if (byte_end) begin
        if (!cur_last && hold_full) begin
          // Next byte follows immediately, no gap slot.
          state     <= ST_DATA;
          bit_idx   <= '0;
          cur_byte  <= hold_data;
          cur_last  <= hold_last;
          cur_nbits <= nbits_of(hold_last, hold_lastb);
          seq_r     <= miller_enc(hold_data[0], prev_x);
          prev_x    <= hold_data[0];
        end else begin
          // End of frame, either requested or because nothing was queued.
          state  <= ST_EOC0;
          seq_r  <= miller_enc(1'b0, prev_x);
          prev_x <= 1'b0;
          if (!cur_last) under_flag <= 1'b1;
        end
      end else if (slot_end) begin
        case (state)
          ST_SOC: begin
            state   <= ST_DATA;
            bit_idx <= '0;
            seq_r   <= miller_enc(cur_byte[0], prev_x);
            prev_x  <= cur_byte[0];
          end
          ST_DATA: begin
            if (!last_bit) begin
              bit_idx <= bit_idx + 3'd1;
              seq_r   <= miller_enc(next_bit, prev_x);
              prev_x  <= next_bit;
            end else begin
              state  <= ST_PAR;
              seq_r  <= miller_enc(par_bit, prev_x);
              prev_x <= par_bit;
            end
          end
          ST_EOC0: begin
            state  <= ST_EOCY;
            seq_r  <= SEQ_Y;
            prev_x <= 1'b0;
          end
          ST_EOCY: begin
            state       <= ST_IDLE;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b1;
            tx_underrun <= under_flag;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  nfca_tx_miller_seq u_seq (
    .clk        (clk),
    .rstn       (rstn),
    .start      (idle_start),
    .run        (tx_busy),
    .seq        (seq_r),
    .carrier_on (carrier_on),
    .slot_end   (slot_end)
  );

endmodule

// File: tb/tb_nfca_tx_frame.sv
// Directed and randomized frames for the NFC-A transmit framer. Each frame's
// carrier waveform is decoded slot by slot and compared with a reference
// built from the bit list and the Modified Miller rule.
module tb_nfca_tx_frame;
  import nfca_pkg::*;

  localparam int T_BIT   = 768;
  localparam int T_PAUSE = 192;
  localparam int T_HALF  = 384;

  localparam logic [1:0] C_X   = 2'd0;
  localparam logic [1:0] C_Y   = 2'd1;
  localparam logic [1:0] C_Z   = 2'd2;
  localparam logic [1:0] C_BAD = 2'd3;

  // ---------------- clock / reset / DUT ----------------
  logic      clk = 1'b0;
  logic      rstn = 1'b0;
  logic      parity_en = 1'b0;
  logic      carrier_on, tx_busy, tx_done, tx_underrun;
  tx_state_t dbg_state;

  nfca_tx_frame_if tx_if ();

  nfca_tx_frame dut (
    .clk         (clk),
    .rstn        (rstn),
    .parity_en   (parity_en),
    .tx          (tx_if),
    .carrier_on  (carrier_on),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_underrun (tx_underrun),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] bytes_q[$];
  logic [1:0] exp_q[$];
  logic [1:0] got_q[$];
  int         got_len;
  logic       got_under;
  logic       got_done;
  logic       busy_ok;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: list every transmitted bit, then map bits to slot shapes.
  function automatic void build_exp(input logic [2:0] lastb, input logic par, input logic ends_last);
    logic bits[$];
    logic prev;
    int   n;
    exp_q.delete();
    foreach (bytes_q[i]) begin
      n = 8;
      if (ends_last && (i == bytes_q.size() - 1) && (lastb != 3'd0)) n = int'(lastb);
      for (int k = 0; k < n; k++) bits.push_back(bytes_q[i][k]);
      if ((n == 8) && par) bits.push_back(~^bytes_q[i]);
    end
    bits.push_back(1'b0);  // EOC starts with a logic 0
    exp_q.push_back(C_Z);  // SOC
    prev = 1'b0;
    foreach (bits[i]) begin
      if (bits[i]) begin
        exp_q.push_back(C_X);
        prev = 1'b1;
      end else begin
        exp_q.push_back(prev ? C_Y : C_Z);
        prev = 1'b0;
      end
    end
    exp_q.push_back(C_Y);  // closing Y
  endfunction

  // ---------------- driver ----------------
  task automatic send_byte(input string tag, input logic [7:0] d, input logic last,
                           input logic [2:0] lb, input logic keep);
    logic ok;
    ok = 1'b0;
    @(negedge clk);
    tx_if.tvalid = 1'b1;
    tx_if.tdata  = d;
    tx_if.tlast  = last;
    tx_if.tlastb = lb;
    for (int w = 0; w < 40000; w++) begin
      if (tx_if.tready === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, " byte accepted"}, ok, 1);
    if (!keep) begin
      #1;
      tx_if.tvalid = 1'b0;
    end
  endtask

  // ---------------- monitor ----------------
  // Called right after the edge that accepted the first byte of a frame.
  task automatic capture_frame(input int max_cycles);
    int   i;
    logic mz, mx, my;
    got_q.delete();
    got_done  = 1'b0;
    got_under = 1'b0;
    got_len   = 0;
    busy_ok   = 1'b1;
    mz = 1'b0; mx = 1'b0; my = 1'b0;
    @(negedge clk);
    for (int j = 0; j < max_cycles; j++) begin
      @(negedge clk);
      i = j % T_BIT;
      if (i == 0) begin
        mz = 1'b0; mx = 1'b0; my = 1'b0;
      end
      if (carrier_on !== (i >= T_PAUSE)) mz = 1'b1;
      if (carrier_on !== !((i >= T_HALF) && (i < T_HALF + T_PAUSE))) mx = 1'b1;
      if (carrier_on !== 1'b1) my = 1'b1;
      if (i == T_BIT - 1)
        got_q.push_back(!mz ? C_Z : (!mx ? C_X : (!my ? C_Y : C_BAD)));
      if (tx_done === 1'b1) begin
        got_done  = 1'b1;
        got_len   = j + 1;
        got_under = tx_underrun;
        break;
      end
      if (tx_busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic compare_frame(input string tag, input logic exp_under);
    int n;
    check({tag, " tx_done seen"}, got_done, 1);
    check({tag, " frame cycles"}, got_len, exp_q.size() * T_BIT);
    check({tag, " slot count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int k = 0; k < n; k++)
      check($sformatf("%s slot %0d", tag, k), got_q[k], exp_q[k]);
    check({tag, " tx_underrun"}, got_under, exp_under);
    check({tag, " busy through frame"}, busy_ok, 1);
    @(negedge clk);
    check({tag, " done one cycle"}, tx_done, 0);
    check({tag, " busy after done"}, tx_busy, 0);
    check({tag, " carrier after done"}, carrier_on, 1);
  endtask

  task automatic send_frame(input string tag, input logic par, input logic ends_last,
                            input logic [2:0] lastb, input logic bp, input logic exp_under);
    int n;
    n = bytes_q.size();
    parity_en = par;
    build_exp(lastb, par, ends_last);
    send_byte(tag, bytes_q[0], ends_last && (n == 1),
              (ends_last && (n == 1)) ? lastb : 3'($urandom_range(0, 7)), bp && (n > 1));
    fork
      capture_frame(exp_q.size() * T_BIT + 2 * T_BIT);
      begin
        for (int i = 1; i < n; i++) begin
          send_byte(tag, bytes_q[i], ends_last && (i == n - 1),
                    (ends_last && (i == n - 1)) ? lastb : 3'($urandom_range(0, 7)),
                    bp && (i < n - 1));
          if (bp && (i == 1)) begin
            #1;
            check({tag, " tready low while holding full"}, tx_if.tready, 0);
          end
        end
      end
    join
    compare_frame(tag, exp_under);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic       seen;
    logic [2:0] bp_lastb;
    tx_if.tvalid = 1'b0;
    tx_if.tdata  = '0;
    tx_if.tlast  = 1'b0;
    tx_if.tlastb = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("reset carrier_on", carrier_on, 1);
    check("reset tx_busy", tx_busy, 0);
    check("reset tx_done", tx_done, 0);
    check("reset tx_underrun", tx_underrun, 0);
    check("reset tx_tready", tx_if.tready, 0);
    check("reset state", dbg_state, ST_IDLE);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("idle tx_tready", tx_if.tready, 1);

    // REQA: 7 bits, no parity after a partial byte
    bytes_q = '{8'h26};
    send_frame("reqa", 1'b1, 1'b1, 3'd7, 1'b0, 1'b0);

    // ANTICOLLISION: two full bytes with parity
    bytes_q = '{8'h93, 8'h20};
    send_frame("anticoll", 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);

    // Back-pressure: four random bytes offered back to back
    bytes_q.delete();
    repeat (4) bytes_q.push_back(8'($urandom_range(0, 255)));
    bp_lastb = 3'($urandom_range(0, 7));
    send_frame("backpressure", 1'($urandom_range(0, 1)), 1'b1, bp_lastb, 1'b1, 1'b0);

    // Underrun: one byte without tlast, nothing follows
    bytes_q = '{8'h55};
    send_frame("underrun", 1'b1, 1'b0, 3'd0, 1'b0, 1'b1);

    // Reset in the pause of bit 3 (an X slot)
    parity_en = 1'b1;
    send_byte("reset_frame", 8'h0F, 1'b1, 3'd0, 1'b0);
    @(negedge clk);
    repeat (4 * T_BIT + T_HALF + 10 + 1) @(negedge clk);
    check("mid-frame pause before reset", carrier_on, 0);
    check("mid-frame busy before reset", tx_busy, 1);
    #2;
    rstn = 1'b0;
    #1;
    check("async reset carrier_on", carrier_on, 1);
    check("async reset tx_busy", tx_busy, 0);
    check("async reset tx_done", tx_done, 0);
    check("async reset tx_tready", tx_if.tready, 0);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (tx_done !== 1'b0 || tx_busy !== 1'b0) seen = 1'b1;
    end
    rstn = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (tx_done !== 1'b0 || tx_busy !== 1'b0 || carrier_on !== 1'b1) seen = 1'b1;
    end
    check("no done or activity after mid-frame reset", seen, 0);

    // Next frame after reset: 0xFF without parity
    bytes_q = '{8'hFF};
    send_frame("ff_nopar", 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
